// File: rtl/cook_timer_ctrl.sv
// Microwave cook-timer control: keypad entry, BCD MM:SS countdown and one-cycle
// set/reset pulses for the downstream magnetron latch.
module cook_timer_ctrl #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       door_closed,
    output logic       S,
    output logic       R,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       cooking,
    output logic       done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SET   = 3'd1;
    localparam logic [2:0] ST_COOK  = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [2:0]    state_q, state_d;
    logic [15:0]   tm_q, tm_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          s_q, s_d;
    logic          r_q, r_d;
    logic          done_q, done_d;
    logic          cooking_q, cooking_d;

    logic          dig_ok;
    logic          tick;
    logic [15:0]   tm_entry;
    logic [15:0]   tm_first;
    logic [15:0]   tm_dec;

    // Time is packed {min_tens, min_ones, sec_tens, sec_ones}; a new digit enters at sec_ones.
    function automatic logic [15:0] shift_in(input logic [15:0] t, input logic [3:0] d);
        return {t[11:0], d};
    endfunction

    // BCD borrow chain; seconds tens wraps to 5 so entered values like 90 still count down.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (t == 16'h0000) begin
            return t;
        end
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    always_comb begin
        state_d  = state_q;
        tm_d     = tm_q;
        presc_d  = '0;
        s_d      = 1'b0;
        r_d      = 1'b0;
        done_d   = 1'b0;

        dig_ok   = digit_valid && (digit <= 4'd9);
        tick     = (state_q == ST_COOK) && (presc_q == PRESC_MAX);
        tm_entry = shift_in(tm_q, digit);
        tm_first = shift_in(16'h0000, digit);
        tm_dec   = bcd_dec(tm_q);

        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    tm_d = 16'h0000;
                end else if (dig_ok) begin
                    tm_d    = tm_entry;
                    state_d = (tm_entry != 16'h0000) ? ST_SET : ST_IDLE;
                end
            end
            ST_SET: begin
                if (clear) begin
                    tm_d    = 16'h0000;
                    state_d = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                    s_d     = 1'b1;
                end else if (dig_ok) begin
                    tm_d    = tm_entry;
                    state_d = (tm_entry != 16'h0000) ? ST_SET : ST_IDLE;
                end
            end
            ST_COOK: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                // Door and stop win over a coincident tick, which is simply dropped.
                if (clear) begin
                    tm_d    = 16'h0000;
                    state_d = ST_IDLE;
                    r_d     = 1'b1;
                end else if (!door_closed || stop) begin
                    state_d = ST_PAUSE;
                    r_d     = 1'b1;
                end else if (tick) begin
                    tm_d = tm_dec;
                    if (tm_dec == 16'h0000) begin
                        state_d = ST_DONE;
                        r_d     = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    tm_d    = 16'h0000;
                    state_d = ST_IDLE;
                end else if (start && door_closed) begin
                    state_d = ST_COOK;
                    s_d     = 1'b1;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    tm_d    = 16'h0000;
                    state_d = ST_IDLE;
                end else if (dig_ok) begin
                    tm_d    = tm_first;
                    state_d = (tm_first != 16'h0000) ? ST_SET : ST_IDLE;
                end else if (!door_closed) begin
                    tm_d    = 16'h0000;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tm_d    = 16'h0000;
                state_d = ST_IDLE;
            end
        endcase

        cooking_d = (state_d == ST_COOK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tm_q      <= 16'h0000;
            presc_q   <= '0;
            s_q       <= 1'b0;
            r_q       <= 1'b1;
            done_q    <= 1'b0;
            cooking_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tm_q      <= tm_d;
            presc_q   <= presc_d;
            s_q       <= s_d;
            r_q       <= r_d;
            done_q    <= done_d;
            cooking_q <= cooking_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign done     = done_q;
    assign cooking  = cooking_q;
    assign min_tens = tm_q[15:12];
    assign min_ones = tm_q[11:8];
    assign sec_tens = tm_q[7:4];
    assign sec_ones = tm_q[3:0];

endmodule
